// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the branch predictor: table entry layout and
// 2-bit saturating counter encodings.
package riscv_core_pkg;

  // Entry fields are sized for the largest supported PC/tag widths; narrower
  // instances zero-extend into them.
  localparam int unsigned BpMaxXlen = 64;
  localparam int unsigned BpMaxTagW = 32;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef struct packed {
    logic                 valid;
    logic [BpMaxTagW-1:0] tag;
    logic [BpMaxXlen-1:0] target;
    logic [1:0]           ctr;
  } bp_entry_t;

endpackage

// File: rtl/riscv_core_sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter.
module riscv_core_sat_counter2
  import riscv_core_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/riscv_core_branch_predictor.sv
// Direct-mapped branch target/direction predictor with one-cycle lookup and
// execute-stage training.
module riscv_core_branch_predictor
  import riscv_core_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 12
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_bp_req_valid,
  input  logic [XLEN-1:0] i_bp_req_pc,
  input  logic            i_bp_stall,
  input  logic            i_bp_flush,
  output logic            o_bp_pred_valid,
  output logic            o_bp_pred_taken,
  output logic [XLEN-1:0] o_bp_pred_target,
  input  logic            i_bp_upd_valid,
  input  logic [XLEN-1:0] i_bp_upd_pc,
  input  logic            i_bp_upd_taken,
  input  logic [XLEN-1:0] i_bp_upd_target,
  input  logic            i_bp_upd_mispredict,
  output logic [31:0]     o_bp_mispredict_cnt
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  bp_entry_t table_q [ENTRIES];
  bp_entry_t table_d [ENTRIES];

  logic [IdxW-1:0]  req_idx, upd_idx;
  logic [TAG_W-1:0] req_tag, upd_tag;
  bp_entry_t        rd_entry, upd_entry;
  logic             req_hit, upd_hit;
  logic [1:0]       upd_ctr;

  logic            pred_valid_q, pred_taken_q;
  logic [XLEN-1:0] pred_target_q, pred_target_d;
  logic            pred_taken_d;
  logic [31:0]     mispredict_cnt_q, mispredict_cnt_d;

  // Index starts at bit 1 so halfword-aligned compressed branches get their own entry.
  assign req_idx = i_bp_req_pc[IdxW:1];
  assign req_tag = i_bp_req_pc[IdxW+TAG_W:IdxW+1];
  assign upd_idx = i_bp_upd_pc[IdxW:1];
  assign upd_tag = i_bp_upd_pc[IdxW+TAG_W:IdxW+1];

  logic unused_upd_pc;
  assign unused_upd_pc = ^{i_bp_upd_pc[XLEN-1:IdxW+TAG_W+1], i_bp_upd_pc[0]};

  assign rd_entry  = table_q[req_idx];
  assign upd_entry = table_q[upd_idx];
  assign req_hit   = rd_entry.valid && (rd_entry.tag == BpMaxTagW'(req_tag));
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == BpMaxTagW'(upd_tag));

  riscv_core_sat_counter2 u_sat_counter2 (
    .cnt_i   (upd_entry.ctr),
    .taken_i (i_bp_upd_taken),
    .cnt_o   (upd_ctr)
  );

  always_comb begin
    table_d = table_q;
    if (i_bp_upd_valid) begin
      if (upd_hit) begin
        table_d[upd_idx].ctr = upd_ctr;
        if (i_bp_upd_taken) table_d[upd_idx].target = BpMaxXlen'(i_bp_upd_target);
      end else if (i_bp_upd_taken) begin
        table_d[upd_idx].valid  = 1'b1;
        table_d[upd_idx].tag    = BpMaxTagW'(upd_tag);
        table_d[upd_idx].target = BpMaxXlen'(i_bp_upd_target);
        table_d[upd_idx].ctr    = WT;
      end
    end
  end

  // Lookup reads table_q, so a same-cycle update is seen only by later requests.
  always_comb begin
    logic [XLEN-1:0] tgt;
    tgt           = req_hit ? XLEN'(rd_entry.target) : i_bp_req_pc + XLEN'(4);
    pred_taken_d  = req_hit && rd_entry.ctr[1];
    pred_target_d = {tgt[XLEN-1:1], 1'b0};
  end

  always_comb begin
    mispredict_cnt_d = mispredict_cnt_q;
    if (i_bp_upd_valid && i_bp_upd_mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
      pred_valid_q     <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_target_q    <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      table_q          <= table_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      if (i_bp_flush) begin
        pred_valid_q <= 1'b0;
      end else if (!i_bp_stall) begin
        pred_valid_q <= i_bp_req_valid;
        if (i_bp_req_valid) begin
          pred_taken_q  <= pred_taken_d;
          pred_target_q <= pred_target_d;
        end
      end
    end
  end

  assign o_bp_pred_valid     = pred_valid_q;
  assign o_bp_pred_taken     = pred_taken_q;
  assign o_bp_pred_target    = pred_target_q;
  assign o_bp_mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_riscv_core_branch_predictor.sv
// Directed self-checking bench for riscv_core_branch_predictor.
module tb_riscv_core_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, stall, flush;
  logic [63:0] req_pc;
  logic        pred_valid, pred_taken;
  logic [63:0] pred_target;
  logic        upd_valid, upd_taken, upd_mispredict;
  logic [63:0] upd_pc, upd_target;
  logic [31:0] mp_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_core_branch_predictor #(
    .XLEN    (64),
    .ENTRIES (16),
    .TAG_W   (12)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_bp_req_valid      (req_valid),
    .i_bp_req_pc         (req_pc),
    .i_bp_stall          (stall),
    .i_bp_flush          (flush),
    .o_bp_pred_valid     (pred_valid),
    .o_bp_pred_taken     (pred_taken),
    .o_bp_pred_target    (pred_target),
    .i_bp_upd_valid      (upd_valid),
    .i_bp_upd_pc         (upd_pc),
    .i_bp_upd_taken      (upd_taken),
    .i_bp_upd_target     (upd_target),
    .i_bp_upd_mispredict (upd_mispredict),
    .o_bp_mispredict_cnt (mp_cnt)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input logic v, input logic [63:0] pc);
    req_valid = v;
    req_pc    = pc;
  endtask

  task automatic upd(input logic v, input logic [63:0] pc, input logic t,
                     input logic [63:0] tgt, input logic mp);
    upd_valid      = v;
    upd_pc         = pc;
    upd_taken      = t;
    upd_target     = tgt;
    upd_mispredict = mp;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pred(input string tag, input logic v, input logic t,
                            input logic [63:0] tgt);
    check({tag, ".valid"}, {63'd0, pred_valid}, {63'd0, v});
    check({tag, ".taken"}, {63'd0, pred_taken}, {63'd0, t});
    check({tag, ".target"}, pred_target, tgt);
  endtask

  initial begin
    // Reset with an update and request also presented; both must be discarded.
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    req(1'b1, 64'h1000);
    upd(1'b1, 64'h1000, 1'b1, 64'h2000, 1'b1);
    tick(); tick();
    check_pred("reset", 1'b0, 1'b0, 64'h0);
    check("reset.cnt", {32'd0, mp_cnt}, 64'd0);

    rst_n = 1'b1;
    upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    req(1'b1, 64'h1000); tick();
    check_pred("first_miss", 1'b1, 1'b0, 64'h1004);
    check("first_miss.cnt", {32'd0, mp_cnt}, 64'd0);

    // Halfword-offset PC trains a distinct entry.
    upd(1'b1, 64'h1002, 1'b1, 64'h3000, 1'b0); req(1'b0, 64'h0); tick();
    check("idle.valid", {63'd0, pred_valid}, 64'd0);
    upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    req(1'b1, 64'h1000); tick();
    check_pred("half_other_miss", 1'b1, 1'b0, 64'h1004);
    req(1'b1, 64'h1002); tick();
    check_pred("half_hit", 1'b1, 1'b1, 64'h3000);

    // Same-cycle allocate and lookup: lookup sees the old (empty) entry.
    upd(1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0); req(1'b1, 64'h1000); tick();
    check_pred("rbw_miss", 1'b1, 1'b0, 64'h1004);
    upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0); tick();
    check_pred("alloc_hit", 1'b1, 1'b1, 64'h2000);
    req(1'b1, 64'h1020); tick();
    check_pred("tag_miss", 1'b1, 1'b0, 64'h1024);

    // Train down: WT -> WNT -> SNT -> SNT.
    req(1'b0, 64'h0); upd(1'b1, 64'h1000, 1'b0, 64'h0, 1'b0); tick();
    req(1'b1, 64'h1000); tick();
    check_pred("wnt_read", 1'b1, 1'b0, 64'h2000);
    req(1'b0, 64'h0); tick();
    // Up from SNT: 0->1 (read sees 0), 1->2, 2->3, 3 stays 3.
    upd(1'b1, 64'h1000, 1'b1, 64'h2400, 1'b0); tick();
    req(1'b1, 64'h1000); tick();
    check_pred("ctr1_read", 1'b1, 1'b0, 64'h2400);
    req(1'b1, 64'h1000); tick();
    check_pred("ctr2_read", 1'b1, 1'b1, 64'h2400);
    req(1'b0, 64'h0); tick();
    upd(1'b1, 64'h1000, 1'b0, 64'h0, 1'b0); req(1'b1, 64'h1000); tick();
    check_pred("ctr3_read", 1'b1, 1'b1, 64'h2400);
    upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0); tick();
    check_pred("ctr2_after_dec", 1'b1, 1'b1, 64'h2400);
    upd(1'b1, 64'h1000, 1'b0, 64'h0, 1'b0); req(1'b0, 64'h0); tick();
    upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0); req(1'b1, 64'h1000); tick();
    check_pred("ctr1_after_dec", 1'b1, 1'b0, 64'h2400);

    // Odd target has bit 0 cleared on output.
    upd(1'b1, 64'h1010, 1'b1, 64'h4001, 1'b0); req(1'b0, 64'h0); tick();
    upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0); req(1'b1, 64'h1010); tick();
    check_pred("odd_target", 1'b1, 1'b1, 64'h4000);

    // Stall holds outputs; flush beats stall and request.
    stall = 1'b1; req(1'b1, 64'h1020); tick();
    check_pred("stall_req", 1'b1, 1'b1, 64'h4000);
    req(1'b0, 64'h0); tick();
    check_pred("stall_idle", 1'b1, 1'b1, 64'h4000);
    flush = 1'b1; req(1'b1, 64'h1000); tick();
    check("flush_stall.valid", {63'd0, pred_valid}, 64'd0);
    stall = 1'b0; flush = 1'b0; tick();
    check_pred("post_flush", 1'b1, 1'b0, 64'h2400);
    flush = 1'b1; tick();
    check("flush_req.valid", {63'd0, pred_valid}, 64'd0);
    flush = 1'b0; req(1'b1, 64'h1002); tick();
    check_pred("table_kept", 1'b1, 1'b1, 64'h3000);

    // Not-taken update that misses leaves the aliasing entry alone.
    upd(1'b1, 64'h1020, 1'b0, 64'h5000, 1'b0); req(1'b0, 64'h0); tick();
    upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0); req(1'b1, 64'h1000); tick();
    check_pred("nt_miss_noalloc", 1'b1, 1'b0, 64'h2400);

    // Mispredict counter.
    req(1'b0, 64'h0);
    upd(1'b0, 64'h1020, 1'b0, 64'h0, 1'b1); tick();
    check("mp_no_valid", {32'd0, mp_cnt}, 64'd0);
    upd(1'b1, 64'h1020, 1'b0, 64'h0, 1'b1); tick();
    check("mp_one", {32'd0, mp_cnt}, 64'd1);
    upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    force dut.mispredict_cnt_q = 32'hFFFF_FFFE;
    tick();
    release dut.mispredict_cnt_q;
    check("mp_forced", {32'd0, mp_cnt}, 64'hFFFF_FFFE);
    upd(1'b1, 64'h1020, 1'b0, 64'h0, 1'b1); tick();
    check("mp_max", {32'd0, mp_cnt}, 64'hFFFF_FFFF);
    tick(); tick();
    check("mp_sat", {32'd0, mp_cnt}, 64'hFFFF_FFFF);

    // Reset clears counter, outputs and table even with an update pending.
    rst_n = 1'b0; req(1'b1, 64'h1000);
    upd(1'b1, 64'h1000, 1'b1, 64'h2000, 1'b1); tick();
    check_pred("reset2", 1'b0, 1'b0, 64'h0);
    check("reset2.cnt", {32'd0, mp_cnt}, 64'd0);
    rst_n = 1'b1; upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    req(1'b1, 64'h1002); tick();
    check_pred("reset2_miss", 1'b1, 1'b0, 64'h1006);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
